// File: rtl/celement_branch_sync_pkg.sv
// ----------------------------------------------------------------------------
// celement_pkg: shared FSM state encoding, branch mask test and sync depths.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package celement_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DLY  = 3'd1,
    ST_REQ  = 3'd2,
    ST_ACK  = 3'd3,
    ST_RTZ  = 3'd4
  } state_t;

  localparam int unsigned MAX_NBR   = 32;
  localparam int unsigned SYNC_NONE = 0;
  localparam int unsigned SYNC_DUAL = 2;

  // True when every selected lane has 'hit' set; unselected lanes never block.
  function automatic logic mask_all(input logic [MAX_NBR-1:0] sel,
                                    input logic [MAX_NBR-1:0] hit);
    return &(hit | ~sel);
  endfunction

endpackage

`default_nettype wire

// File: rtl/celement_branch_sync_if.sv
// ----------------------------------------------------------------------------
// celement_branch_sync_if: upstream/downstream handshake bundle of the stage.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface celement_branch_sync_if #(
  parameter int unsigned NBR   = 2,
  parameter int unsigned CNT_W = 8
);
  logic             LOPEN;
  logic             SENDIN;
  logic             ACKOUT;
  logic [NBR-1:0]   EXBIN;
  logic [NBR-1:0]   SENDOUT;
  logic [NBR-1:0]   ACKIN;
  logic             CP;
  logic             BUSY;
  logic [CNT_W-1:0] TOKCNT;

  modport master (
    output LOPEN, SENDIN, EXBIN, ACKIN,
    input  ACKOUT, SENDOUT, CP, BUSY, TOKCNT
  );

  modport slave (
    input  LOPEN, SENDIN, EXBIN, ACKIN,
    output ACKOUT, SENDOUT, CP, BUSY, TOKCNT
  );
endinterface

`default_nettype wire

// File: rtl/celement_branch_sync_sync.sv
// ----------------------------------------------------------------------------
// celement_sync: DEPTH-deep reset-to-0 flop chain; DEPTH=0 degenerates to a wire.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module celement_sync #(
  parameter int unsigned DEPTH = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic w_unused;
      assign w_unused = clk ^ rst;
      assign q_o      = d_i;
    end else begin : g_flops
      logic [DEPTH-1:0] chain_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          chain_q <= '0;
        end else begin
          chain_q[0] <= d_i;
          for (int i = 1; i < DEPTH; i++) begin
            chain_q[i] <= chain_q[i-1];
          end
        end
      end

      assign q_o = chain_q[DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/celement_branch_sync.sv
// ----------------------------------------------------------------------------
// celement_branch_sync: clocked exclusive-branch 4-phase stage with send delay
// and completed-token counter. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module celement_branch_sync
  import celement_pkg::*;
#(
  parameter int unsigned NBR      = 2,
  parameter int unsigned SEND_DLY = 4,
  parameter int unsigned SYNC     = SYNC_NONE,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  celement_branch_sync_if.slave bus
);

  localparam int unsigned DLY_W = (SEND_DLY > 1) ? $clog2(SEND_DLY + 1) : 1;

  logic             s_req;
  logic [NBR-1:0]   s_ack;

  state_t           state_q,   state_d;
  logic [NBR-1:0]   sel_q,     sel_d;
  logic [DLY_W-1:0] cnt_q,     cnt_d;
  logic [CNT_W-1:0] tokcnt_q,  tokcnt_d;
  logic [NBR-1:0]   sendout_q, sendout_d;
  logic             ackout_q,  ackout_d;
  logic             cp_q,      cp_d;
  logic             busy_q,    busy_d;

  logic               accept;
  logic               done;
  logic               released;
  logic [MAX_NBR-1:0] sel_ext;
  logic [MAX_NBR-1:0] ack_ext;

  celement_sync #(.DEPTH(SYNC)) u_sync_req (
    .clk (CLK),
    .rst (RESET),
    .d_i (bus.SENDIN),
    .q_o (s_req)
  );

  generate
    for (genvar g = 0; g < NBR; g++) begin : g_ack_sync
      celement_sync #(.DEPTH(SYNC)) u_sync_ack (
        .clk (CLK),
        .rst (RESET),
        .d_i (bus.ACKIN[g]),
        .q_o (s_ack[g])
      );
    end
  endgenerate

  always_comb begin
    sel_ext            = '0;
    sel_ext[NBR-1:0]   = sel_q;
    ack_ext            = '0;
    ack_ext[NBR-1:0]   = s_ack;
  end

  assign accept   = (state_q == ST_IDLE) && s_req && !bus.LOPEN;
  assign done     = mask_all(sel_ext, ack_ext);
  assign released = mask_all(sel_ext, ~ack_ext);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      cnt_q     <= '0;
      tokcnt_q  <= '0;
      sendout_q <= '0;
      ackout_q  <= 1'b0;
      cp_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      tokcnt_q  <= tokcnt_d;
      sendout_q <= sendout_d;
      ackout_q  <= ackout_d;
      cp_q      <= cp_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    tokcnt_d = tokcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sel_d   = bus.EXBIN;
          cnt_d   = DLY_W'(SEND_DLY);
          state_d = (SEND_DLY > 0) ? ST_DLY : ST_REQ;
        end
      end
      ST_DLY: begin
        cnt_d = cnt_q - DLY_W'(1);
        if (cnt_q == DLY_W'(1)) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (done) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!s_req) begin
          state_d = ST_RTZ;
        end
      end
      ST_RTZ: begin
        if (released) begin
          state_d  = ST_IDLE;
          tokcnt_d = tokcnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered, so each is the value the next cycle should show.
  always_comb begin
    sendout_d = '0;
    ackout_d  = 1'b0;
    cp_d      = accept;
    busy_d    = (state_d != ST_IDLE);
    case (state_q)
      ST_REQ: begin
        sendout_d = sel_q;
        ackout_d  = done;
      end
      ST_ACK: begin
        sendout_d = s_req ? sel_q : '0;
        ackout_d  = 1'b1;
      end
      ST_RTZ: begin
        ackout_d  = !released;
      end
      default: ;
    endcase
  end

  assign bus.SENDOUT = sendout_q;
  assign bus.ACKOUT  = ackout_q;
  assign bus.CP      = cp_q;
  assign bus.BUSY    = busy_q;
  assign bus.TOKCNT  = tokcnt_q;

endmodule

`default_nettype wire

// File: tb/tb_celement_branch_sync.sv
// ----------------------------------------------------------------------------
// tb_celement_branch_sync: table-driven bench over two configurations
// (SEND_DLY=4/CNT_W=8 and SEND_DLY=0/CNT_W=2). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_celement_branch_sync;

  logic clk;
  logic rst;

  celement_branch_sync_if #(.NBR(2), .CNT_W(8)) ifa ();
  celement_branch_sync_if #(.NBR(2), .CNT_W(2)) ifb ();

  celement_branch_sync #(.NBR(2), .SEND_DLY(4), .SYNC(0), .CNT_W(8)) u_dut_a (
    .CLK   (clk),
    .RESET (rst),
    .bus   (ifa)
  );

  celement_branch_sync #(.NBR(2), .SEND_DLY(0), .SYNC(0), .CNT_W(2)) u_dut_b (
    .CLK   (clk),
    .RESET (rst),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         b;
    logic       lopen;
    logic       sendin;
    logic [1:0] ex;
    logic [1:0] ack;
    logic [1:0] so;
    logic       ao;
    logic       cp;
    logic       busy;
    logic [7:0] tok;
  } vec_t;

  typedef struct {
    string       name;
    logic [12:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_vec    = 0;

  function automatic void add(input int b, input int lopen, input int sendin,
                              input int ex, input int ack, input int so,
                              input int ao, input int cp, input int busy,
                              input int tok);
    vec_t v;
    v.b      = (b != 0);
    v.lopen  = 1'(lopen);
    v.sendin = 1'(sendin);
    v.ex     = 2'(ex);
    v.ack    = 2'(ack);
    v.so     = 2'(so);
    v.ao     = 1'(ao);
    v.cp     = 1'(cp);
    v.busy   = 1'(busy);
    v.tok    = 8'(tok);
    vecs.push_back(v);
  endfunction

  // One full token on the SEND_DLY=4 instance, accept through return to IDLE.
  function automatic void add_token_a(input int lopen, input int ex, input int tok);
    add(0, 0,     1, ex, 0,  0,  0, 1, 1, tok);
    for (int i = 0; i < 4; i++) add(0, lopen, 1, ex, 0, 0, 0, 0, 1, tok);
    add(0, lopen, 1, ex, 0,  ex, 0, 0, 1, tok);
    add(0, lopen, 1, ex, ex, ex, 1, 0, 1, tok);
    add(0, lopen, 0, ex, ex, 0,  1, 0, 1, tok);
    add(0, lopen, 0, ex, 0,  0,  0, 0, 0, tok + 1);
  endfunction

  function automatic logic [12:0] sample(input bit b);
    if (b) return {ifb.SENDOUT, ifb.ACKOUT, ifb.CP, ifb.BUSY, 6'b0, ifb.TOKCNT};
    return {ifa.SENDOUT, ifa.ACKOUT, ifa.CP, ifa.BUSY, ifa.TOKCNT};
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got so=%b ao=%b cp=%b busy=%b tok=%0d, want so=%b ao=%b cp=%b busy=%b tok=%0d",
               name, act[12:11], act[10], act[9], act[8], act[7:0],
               exp[12:11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic step(input vec_t v);
    sb_t e;
    @(negedge clk);
    if (v.b) begin
      ifb.LOPEN = v.lopen; ifb.SENDIN = v.sendin; ifb.EXBIN = v.ex; ifb.ACKIN = v.ack;
    end else begin
      ifa.LOPEN = v.lopen; ifa.SENDIN = v.sendin; ifa.EXBIN = v.ex; ifa.ACKIN = v.ack;
    end
    sbq.push_back('{$sformatf("vec%0d_%s", n_vec, v.b ? "b" : "a"),
                    {v.so, v.ao, v.cp, v.busy, v.tok}});
    n_vec++;
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check(e.name, sample(v.b), e.exp);
  endtask

  task automatic play();
    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ifa.LOPEN = 1'b0; ifa.SENDIN = 1'b0; ifa.EXBIN = 2'b00; ifa.ACKIN = 2'b00;
    ifb.LOPEN = 1'b0; ifb.SENDIN = 1'b0; ifb.EXBIN = 2'b00; ifb.ACKIN = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_a", sample(1'b0), 13'd0);
    check("reset_b", sample(1'b1), 13'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single branch, fork with staggered acks, deselected-ack/EXBIN noise.
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_token_a(0, 1, 0);
    add(0, 0, 1, 3, 0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 3, 0, 0, 0, 0, 1, 1);
    add(0, 0, 1, 3, 0, 3, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 3, 1, 3, 0, 0, 1, 1);
    add(0, 0, 1, 3, 3, 3, 1, 0, 1, 1);
    add(0, 0, 0, 3, 3, 0, 1, 0, 1, 1);
    for (int i = 0; i < 2; i++) add(0, 0, 0, 3, 2, 0, 1, 0, 1, 1);
    add(0, 0, 0, 3, 0, 0, 0, 0, 0, 2);
    add(0, 0, 1, 2, 0, 0, 0, 1, 1, 2);
    add(0, 0, 1, 1, 0, 0, 0, 0, 1, 2);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1, 2);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1, 2);
    add(0, 0, 1, 3, 0, 0, 0, 0, 1, 2);
    add(0, 0, 1, 3, 1, 2, 0, 0, 1, 2);
    add(0, 0, 1, 1, 0, 2, 0, 0, 1, 2);
    add(0, 0, 1, 0, 1, 2, 0, 0, 1, 2);
    add(0, 0, 1, 0, 3, 2, 1, 0, 1, 2);
    add(0, 0, 0, 0, 3, 0, 1, 0, 1, 2);
    add(0, 0, 0, 0, 2, 0, 1, 0, 1, 2);
    add(0, 0, 0, 1, 1, 0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    // Bring a token up to REQ with SENDOUT=01, then reset under it.
    add(0, 0, 1, 1, 0, 0, 0, 1, 1, 3);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 1, 0, 0, 0, 0, 1, 3);
    add(0, 0, 1, 1, 0, 1, 0, 0, 1, 3);
    play();

    @(negedge clk);
    rst = 1'b1;
    ifa.SENDIN = 1'b0;
    #1;
    check("reset_async_a", sample(1'b0), 13'd0);
    @(posedge clk);
    #1;
    check("reset_hold_a", sample(1'b0), 13'd0);
    @(negedge clk);
    rst = 1'b0;

    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_token_a(0, 1, 0);
    // LOPEN holds IDLE, then opens for one accept and is closed again in flight.
    for (int i = 0; i < 20; i++) add(0, 1, 1, 1, 0, 0, 0, 0, 0, 1);
    add_token_a(1, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 1, 0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 2);

    // Instance B: skip with deselected acks, back-to-back, wrap, early SENDIN drop.
    add(1, 0, 1, 0, 0, 0, 0, 1, 1, 0);
    add(1, 0, 1, 0, 3, 0, 1, 0, 1, 0);
    add(1, 0, 0, 0, 3, 0, 1, 0, 1, 0);
    add(1, 0, 0, 0, 3, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 0, 1, 1, 0, 0, 0, 1, 1, 1);
    add(1, 0, 1, 1, 0, 1, 0, 0, 1, 1);
    add(1, 0, 1, 1, 1, 1, 1, 0, 1, 1);
    add(1, 0, 0, 1, 1, 0, 1, 0, 1, 1);
    add(1, 0, 1, 1, 1, 0, 1, 0, 1, 1);
    add(1, 0, 1, 1, 0, 0, 0, 0, 0, 2);
    add(1, 0, 1, 1, 0, 0, 0, 1, 1, 2);
    add(1, 0, 1, 1, 0, 1, 0, 0, 1, 2);
    add(1, 0, 1, 1, 1, 1, 1, 0, 1, 2);
    add(1, 0, 0, 1, 1, 0, 1, 0, 1, 2);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 3);
    add(1, 0, 1, 1, 0, 0, 0, 1, 1, 3);
    add(1, 0, 1, 1, 0, 1, 0, 0, 1, 3);
    add(1, 0, 1, 1, 1, 1, 1, 0, 1, 3);
    add(1, 0, 0, 1, 1, 0, 1, 0, 1, 3);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 0, 0, 1, 1, 0);
    add(1, 0, 0, 1, 0, 1, 0, 0, 1, 0);
    add(1, 0, 0, 1, 1, 1, 1, 0, 1, 0);
    add(1, 0, 0, 1, 1, 0, 1, 0, 1, 0);
    add(1, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    play();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
